// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1; 8E1 when RVSTEEL_UART_RX_PARITY_EN is defined) feeding a small byte FIFO.
// Latency: a good byte appears on rx_valid one cycle after its stop-bit sample.
// Backpressure: rx_valid/rx_ready handshake; a good byte arriving at a full FIFO is dropped with an overflow pulse.
module uart_rx_buffered #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int UART_BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overflow,
  output logic       parity_error
);

  // Bit timing in clock cycles.
  localparam int P    = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int HALF = P / 2;
  localparam int CW   = $clog2(P + 1);
  localparam logic [CW-1:0] P_LAST    = CW'(P - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  // FIFO pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef RVSTEEL_UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    shift, shift_next;
  logic [1:0]    sync_q;
  logic          rx_sync;
  logic          push;
  logic          ferr_set;
`ifdef RVSTEEL_UART_RX_PARITY_EN
  logic          par_bit, par_next;
  logic          par_bad;
  logic          perr_set;
`endif

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          empty, full, pop, do_push, drop;

  // Two-flop synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], uart_rx};
  end

  assign rx_sync = sync_q[1];

`ifdef RVSTEEL_UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must contain an even number of ones.
  assign par_bad = ^{shift, par_bit};
`endif

  // Receiver state, timing counters and shift register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef RVSTEEL_UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
`ifdef RVSTEEL_UART_RX_PARITY_EN
      par_bit <= par_next;
`endif
    end
  end

  // Next-state logic: frame sequencing and sample points.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    bit_next   = bit_cnt;
    shift_next = shift;
    push       = 1'b0;
    ferr_set   = 1'b0;
`ifdef RVSTEEL_UART_RX_PARITY_EN
    par_next   = par_bit;
    perr_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_sync) state_next = START;
      end
      START: begin
        // Mid start bit: a high line here means the falling edge was a glitch.
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (rx_sync) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            bit_next   = '0;
          end
        end
      end
      DATA: begin
        if (cnt == P_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef RVSTEEL_UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef RVSTEEL_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == P_LAST) begin
          cnt_next   = '0;
          par_next   = rx_sync;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        // A bad stop bit takes priority over a parity mismatch.
        if (cnt == P_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (!rx_sync) begin
            ferr_set   = 1'b1;
            state_next = WAIT_HIGH;
          end
`ifdef RVSTEEL_UART_RX_PARITY_EN
          else if (par_bad) begin
            perr_set = 1'b1;
          end
`endif
          else begin
            push = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off new frames until the line has returned to idle.
        cnt_next = '0;
        if (rx_sync) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Error pulses, registered so each lasts exactly one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_error <= ferr_set;
      overflow    <= drop;
    end
  end

`ifdef RVSTEEL_UART_RX_PARITY_EN
  // Parity error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) parity_error <= 1'b0;
    else        parity_error <= perr_set;
  end
`else
  assign parity_error = 1'b0;
`endif

  // FIFO status; a pop while full frees the slot the simultaneous push needs.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && rx_ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  // FIFO pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are only visible through the head when non-empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shift;
  end

  assign rx_valid = !empty;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Randomized scoreboard bench for uart_rx_buffered at P = 10 cycles, FIFO_DEPTH = 4.
// Stimulus drives serial frames and pushes predicted bytes/events; a monitor pops and compares.
// Build with RVSTEEL_UART_RX_PARITY_EN defined to exercise the even-parity frame.
module tb_uart_rx_buffered;

  localparam int P     = 10;
  localparam int DEPTH = 4;
`ifdef RVSTEEL_UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overflow;
  logic       parity_error;

  logic       fixed_ready = 1'b0;
  logic       rand_mode = 1'b0;
  logic       rand_bit = 1'b0;
  assign rx_ready = rand_mode ? rand_bit : fixed_ready;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ovf = 0, exp_pe = 0;
  int obs_fe = 0, obs_ovf = 0, obs_pe = 0, obs_valid = 0;

  uart_rx_buffered #(
    .CLOCK_FREQUENCY(1000000),
    .UART_BAUD_RATE (100000),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .overflow    (overflow),
    .parity_error(parity_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Random consumer readiness, used only while rand_mode is set.
  initial forever begin
    @(posedge clock);
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: counts error pulses and pops/compares every accepted byte.
  initial begin
    logic [7:0] held;
    logic       hold_vld;
    hold_vld = 1'b0;
    held     = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hold_vld = 1'b0;
      end else begin
        if (frame_error)  obs_fe++;
        if (overflow)     obs_ovf++;
        if (parity_error) obs_pe++;
        if (rx_valid)     obs_valid++;
        if (hold_vld && rx_valid) check("rx_data_stable", int'(rx_data), int'(held));
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got 0x%02h, expected no byte", rx_data);
          end else begin
            check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
          end
        end
        hold_vld = rx_valid && !rx_ready;
        held     = rx_data;
      end
    end
  end

  // Reference model + serial driver for one frame.
  // stop: level of the stop bit; par_flip: send the wrong parity bit (parity builds);
  // ready_pulse: raise rx_ready for exactly the stop-bit sample cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                            input logic ready_pulse);
    logic bits [11];
    int   nb;
    int   pulse_at;
    if (!stop)                            exp_fe++;
    else if (PARITY_ON && par_flip)       exp_pe++;
    else if (exp_q.size() >= DEPTH && !ready_pulse) exp_ovf++;
    else                                  exp_q.push_back(d);

    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = d[k];
    if (PARITY_ON) begin
      bits[9]  = (^d) ^ par_flip;
      bits[10] = stop;
      nb = 11;
    end else begin
      bits[9]  = stop;
      bits[10] = 1'b1;
      nb = 10;
    end
    // Stop sample: 2 sync cycles + half bit into the start bit + one bit per later sample.
    pulse_at = 2 + 1 + P / 2 + (nb - 1) * P - 1;
    for (int i = 0; i < nb * P; i++) begin
      uart_rx = bits[i / P];
      if (ready_pulse) fixed_ready = (i == pulse_at);
      tick(1);
    end
    uart_rx = 1'b1;
    tick(6);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    tick(2);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_events(input string tag);
    check({tag, "_frame_error_pulses"}, obs_fe, exp_fe);
    check({tag, "_overflow_pulses"}, obs_ovf, exp_ovf);
    check({tag, "_parity_error_pulses"}, obs_pe, exp_pe);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_valid"}, int'(rx_valid), 0);
    check({tag, "_rx_data"}, int'(rx_data), 0);
    check({tag, "_frame_error"}, int'(frame_error), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_parity_error"}, int'(parity_error), 0);
  endtask

  initial begin
    int v0;
    // Reset state.
    tick(3);
    check_idle_outputs("reset");
    reset = 1'b1;
    tick(5);

    // Single byte with the consumer always ready: one-cycle rx_valid.
    fixed_ready = 1'b1;
    v0 = obs_valid;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    wait_drain("drain_55");
    check("valid_cycles_55", obs_valid - v0, 1);
    check_events("byte55");

    // Short low glitch on the idle line.
    v0 = obs_valid;
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    check("valid_cycles_glitch", obs_valid - v0, 0);
    check_events("glitch");

    // Bad stop bit, then a clean byte.
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    check("fifo_empty_after_ferr", int'(rx_valid), 0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_drain("drain_3c");
    check_events("ferr");

    // Overflow: five bytes into a depth-4 FIFO with no consumer.
    fixed_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0);
    check_events("overflow");
    fixed_ready = 1'b1;
    wait_drain("drain_overflow");

    // Full FIFO with a pop on the exact push cycle.
    fixed_ready = 1'b0;
    for (int b = 0; b < DEPTH; b++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
    send_frame(8'h77, 1'b1, 1'b0, 1'b1);
    check_events("push_pop_full");
    fixed_ready = 1'b1;
    wait_drain("drain_77");

    // Reset mid-frame at data bit 4 of 8'hFF.
    uart_rx = 1'b0;
    tick(P);
    uart_rx = 1'b1;
    tick(4 * P + 3);
    reset = 1'b0;
    tick(3);
    check_idle_outputs("midframe_reset");
    reset = 1'b1;
    v0 = obs_valid;
    tick(P * 12);
    check("valid_cycles_after_reset", obs_valid - v0, 0);
    check_events("after_reset");
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    wait_drain("drain_12");

`ifdef RVSTEEL_UART_RX_PARITY_EN
    // Parity: 8'h07 with wrong then right even-parity bit.
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("no_valid_on_parity_error", int'(rx_valid), 0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    wait_drain("drain_07");
    check_events("parity");
`endif

    // Random traffic with a randomly stalling consumer.
    rand_mode = 1'b1;
    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 3) == 0), 1'b0);
    end
    wait_drain("drain_random");
    check_events("random");
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
